spi_lcd_ctrl: RTL

SPI_LCD_CTRL -- requirements
Module: spi_lcd_ctrl

---
 rtl/spi_lcd_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/spi_lcd_ctrl.sv
// LCD init sequencer: walks a 64-entry command/data/delay table into a 16-bit
// SPI serializer, then forwards pixel words one at a time on request.
module spi_lcd_ctrl #(
  parameter int unsigned DLY_UNIT = 27000,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic [5:0]  o_rom_addr,
  input  logic [17:0] i_rom_data,
  output logic        o_spi_we,
  output logic [15:0] o_spi_data,
  output logic        o_dc,
  input  logic        i_spi_done,
  input  logic        i_px_valid,
  input  logic [15:0] i_px_data,
  output logic        o_px_ready,
  output logic        o_busy,
  output logic        o_init_done,
  output logic        o_err
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_SEND      = 4'd3;
  localparam logic [3:0] S_WAIT_DONE = 4'd4;
  localparam logic [3:0] S_DELAY     = 4'd5;
  localparam logic [3:0] S_READY     = 4'd6;
  localparam logic [3:0] S_PX_WAIT   = 4'd7;
  localparam logic [3:0] S_ERR       = 4'd8;

  localparam int DW = 16 + $clog2(DLY_UNIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [3:0]    state_q, state_d;
  logic [5:0]    addr_q, addr_d;
  logic          we_q, we_d;
  logic [15:0]   data_q, data_d;
  logic          dc_q, dc_d;
  logic          init_q, init_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [DW-1:0] dly_q, dly_d;
  logic          advance;

  always_comb begin
    // NOTE: every next-state signal gets a default before the case so no latch is inferred.
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    data_d  = data_q;
    dc_d    = dc_q;
    init_d  = init_q;
    err_d   = err_q;
    tmr_d   = tmr_q;
    dly_d   = dly_q;
    advance = 1'b0;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (i_start) begin
          state_d = S_FETCH;
          addr_d  = '0;
          init_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (i_rom_data[17:16])
          2'b00, 2'b01: begin
            dc_d    = i_rom_data[16];
            data_d  = i_rom_data[15:0];
            we_d    = 1'b1;
            state_d = S_SEND;
          end
          2'b10: begin
            if (i_rom_data[15:0] == 16'd0) begin
              advance = 1'b1;
            end else begin
              // Counts down to zero, so load one less than the clocks to spend here.
              dly_d   = DW'(i_rom_data[15:0]) * DW'(DLY_UNIT) - DW'(1);
              state_d = S_DELAY;
            end
          end
          default: begin
            init_d  = 1'b1;
            state_d = S_READY;
          end
        endcase
      end
      S_SEND: begin
        // Strobe was one clock ago; expiry lands TIMEOUT clocks after it.
        tmr_d   = TW'(TIMEOUT - 2);
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (i_spi_done) begin
          advance = 1'b1;
        end else if (tmr_q == '0) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_DELAY: begin
        if (dly_q == '0) advance = 1'b1;
        else             dly_d   = dly_q - DW'(1);
      end
      S_READY: begin
        if (i_start) begin
          state_d = S_FETCH;
          addr_d  = '0;
          init_d  = 1'b0;
          err_d   = 1'b0;
        end else if (i_px_valid) begin
          data_d  = i_px_data;
          dc_d    = 1'b1;
          we_d    = 1'b1;
          tmr_d   = TW'(TIMEOUT - 1);
          state_d = S_PX_WAIT;
        end
      end
      S_PX_WAIT: begin
        if (i_spi_done) begin
          state_d = S_READY;
        end else if (tmr_q == '0) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The last table slot acts as an implicit end entry rather than wrapping.
    if (advance) begin
      if (addr_q == 6'd63) begin
        init_d  = 1'b1;
        state_d = S_READY;
      end else begin
        addr_d  = addr_q + 6'd1;
        state_d = S_FETCH;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (i_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      dc_q    <= 1'b0;
      init_q  <= 1'b0;
      err_q   <= 1'b0;
      tmr_q   <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      data_q  <= data_d;
      dc_q    <= dc_d;
      init_q  <= init_d;
      err_q   <= err_d;
      tmr_q   <= tmr_d;
      dly_q   <= dly_d;
    end
  end

  assign o_rom_addr  = addr_q;
  assign o_spi_we    = we_q;
  assign o_spi_data  = data_q;
  assign o_dc        = dc_q;
  assign o_init_done = init_q;
  assign o_err       = err_q;
  assign o_px_ready  = (state_q == S_READY);
  assign o_busy      = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                       (state_q == S_SEND) || (state_q == S_WAIT_DONE) ||
                       (state_q == S_DELAY) || (state_q == S_PX_WAIT);

endmodule
